// File: rtl/ir_key_decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : ir_key_decode_if
//  Description : Signal bundle between the NEC IR receiver (frame fields,
//                leader flag, bit count) and the key decoder outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface ir_key_decode_if;
    // Receiver side
    logic        lead_flag_I;
    logic [5:0]  vaild_cnt_I;
    logic [3:0]  clu_I;
    logic [3:0]  cll_I;
    logic [3:0]  cru_I;
    logic [3:0]  crl_I;
    logic [3:0]  ku_I;
    logic [3:0]  kl_I;
    logic [3:0]  iku_I;
    logic [3:0]  ikl_I;
    // Decoder results
    logic [7:0]  key_code_O;
    logic [15:0] custom_O;
    logic        key_valid_O;
    logic        key_repeat_O;
    logic        key_held_O;
    logic        err_O;
    logic [7:0]  frame_cnt_O;
    logic [6:0]  HEX0_O;
    logic [6:0]  HEX1_O;
    logic [6:0]  HEX2_O;
    logic [6:0]  HEX3_O;

    // Receiver / stimulus side
    modport master (
        output lead_flag_I, vaild_cnt_I,
        output clu_I, cll_I, cru_I, crl_I, ku_I, kl_I, iku_I, ikl_I,
        input  key_code_O, custom_O, key_valid_O, key_repeat_O, key_held_O,
        input  err_O, frame_cnt_O, HEX0_O, HEX1_O, HEX2_O, HEX3_O
    );

    // Decoder side
    modport slave (
        input  lead_flag_I, vaild_cnt_I,
        input  clu_I, cll_I, cru_I, crl_I, ku_I, kl_I, iku_I, ikl_I,
        output key_code_O, custom_O, key_valid_O, key_repeat_O, key_held_O,
        output err_O, frame_cnt_O, HEX0_O, HEX1_O, HEX2_O, HEX3_O
    );
endinterface
`default_nettype wire

// File: rtl/ir_key_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ir_key_decode
//  Description : Frame-level consumer for the NEC IR receiver. Detects frame
//                end from the leader flag, validates key/custom codes, emits
//                key / repeat / error pulses, a held-key level, a frame
//                counter and four active-low seven-segment digits.
//  Revision    : 1.0  initial release
// ============================================================================
module ir_key_decode #(
    parameter int          HOLD_CYCLES   = 6_000_000,
    parameter bit          CHECK_CUSTOM  = 1'b0,
    parameter logic [15:0] EXPECT_CUSTOM = 16'h00FF
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    ir_key_decode_if.slave    bus
);

    localparam logic [1:0]  c_IDLE        = 2'd0;
    localparam logic [1:0]  c_RECV        = 2'd1;
    localparam logic [1:0]  c_CHECK       = 2'd2;
    localparam logic [22:0] c_HOLD_RELOAD = 23'(HOLD_CYCLES - 1);
    localparam logic [6:0]  c_SEG_ZERO    = 7'h40;

    // Active-low {g..a} pattern for one hex digit
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic        r_lead;
    logic [5:0]  r_cnt;
    logic        r_armed;
    logic [1:0]  r_state;
    logic [5:0]  r_max_cnt;
    logic [7:0]  r_key_sh;
    logic [7:0]  r_inv_sh;
    logic [15:0] r_cust_sh;
    logic [7:0]  r_key_code;
    logic [15:0] r_custom;
    logic        r_key_valid;
    logic        r_key_repeat;
    logic        r_err;
    logic        r_held;
    logic [22:0] r_hold_cnt;
    logic [7:0]  r_frame_cnt;
    logic [6:0]  r_hex0;
    logic [6:0]  r_hex1;
    logic [6:0]  r_hex2;
    logic [6:0]  r_hex3;

    logic        w_check;
    logic        w_key_ok;
    logic        w_cust_ok;
    logic        w_accept;
    logic        w_repeat;
    logic        w_reject;
    logic        w_reload;

    // Frame verdict, only meaningful during the single CHECK cycle
    assign w_check   = (r_state == c_CHECK);
    assign w_key_ok  = (r_key_sh == ~r_inv_sh);
    assign w_cust_ok = !CHECK_CUSTOM || (r_cust_sh == EXPECT_CUSTOM);
    assign w_accept  = w_check && (r_max_cnt == 6'd32) && w_key_ok && w_cust_ok;
    assign w_repeat  = w_check && (r_max_cnt == 6'd0) && r_held;
    // Any non-repeat length that did not pass is an error (truncated or bad code)
    assign w_reject  = w_check && (r_max_cnt != 6'd0) && !w_accept;
    assign w_reload  = w_accept || w_repeat;

    // Register receiver status; arm only after the leader has been seen low,
    // so a frame already in progress at reset release is ignored
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_lead  <= 1'b0;
            r_cnt   <= 6'd0;
            r_armed <= 1'b0;
        end else begin
            r_lead  <= bus.lead_flag_I;
            r_cnt   <= bus.vaild_cnt_I;
            r_armed <= r_armed | ~bus.lead_flag_I;
        end
    end

    // Frame FSM: track longest bit count, shadow the fields at frame end
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_max_cnt <= 6'd0;
            r_key_sh  <= 8'd0;
            r_inv_sh  <= 8'd0;
            r_cust_sh <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_max_cnt <= 6'd0;
                    if (r_lead && r_armed)
                        r_state <= c_RECV;
                end
                c_RECV: begin
                    if (r_cnt > r_max_cnt)
                        r_max_cnt <= r_cnt;
                    if (!r_lead) begin
                        r_state   <= c_CHECK;
                        r_key_sh  <= {bus.kl_I, bus.ku_I};
                        r_inv_sh  <= {bus.ikl_I, bus.iku_I};
                        r_cust_sh <= {bus.crl_I, bus.cru_I, bus.cll_I, bus.clu_I};
                    end
                end
                c_CHECK: r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Event pulses, latched codes and valid-frame counter
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_key_valid  <= 1'b0;
            r_key_repeat <= 1'b0;
            r_err        <= 1'b0;
            r_key_code   <= 8'd0;
            r_custom     <= 16'd0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_key_valid  <= w_accept;
            r_key_repeat <= w_repeat;
            r_err        <= w_reject;
            if (w_accept) begin
                r_key_code  <= r_key_sh;
                r_custom    <= r_cust_sh;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Held-key timer; a reload in the expiry cycle keeps the key held
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_held     <= 1'b0;
            r_hold_cnt <= 23'd0;
        end else if (w_reload) begin
            r_held     <= 1'b1;
            r_hold_cnt <= c_HOLD_RELOAD;
        end else if (r_held) begin
            if (r_hold_cnt == 23'd0)
                r_held <= 1'b0;
            else
                r_hold_cnt <= r_hold_cnt - 23'd1;
        end
    end

    // Seven-segment digits, one cycle behind the latched codes
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_hex0 <= c_SEG_ZERO;
            r_hex1 <= c_SEG_ZERO;
            r_hex2 <= c_SEG_ZERO;
            r_hex3 <= c_SEG_ZERO;
        end else begin
            r_hex0 <= seg7(r_key_code[3:0]);
            r_hex1 <= seg7(r_key_code[7:4]);
            r_hex2 <= seg7(r_custom[3:0]);
            r_hex3 <= seg7(r_custom[7:4]);
        end
    end

    assign bus.key_code_O   = r_key_code;
    assign bus.custom_O     = r_custom;
    assign bus.key_valid_O  = r_key_valid;
    assign bus.key_repeat_O = r_key_repeat;
    assign bus.key_held_O   = r_held;
    assign bus.err_O        = r_err;
    assign bus.frame_cnt_O  = r_frame_cnt;
    assign bus.HEX0_O       = r_hex0;
    assign bus.HEX1_O       = r_hex1;
    assign bus.HEX2_O       = r_hex2;
    assign bus.HEX3_O       = r_hex3;

endmodule
`default_nettype wire

// File: tb/tb_ir_key_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ir_key_decode
//  Description : Directed frames into ir_key_decode; expected events go into
//                a scoreboard queue that a negedge monitor drains.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ir_key_decode;

    localparam int HOLD = 200;

    typedef struct {
        logic [2:0] kind;   // {valid, repeat, err}
        logic [7:0] key;
        logic [7:0] fc;
        logic       held;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   last_reload;
    logic prev_held;
    logic [7:0] m_fc;
    exp_t sb_q[$];

    ir_key_decode_if bus();

    ir_key_decode #(
        .HOLD_CYCLES   (HOLD),
        .CHECK_CUSTOM  (1'b1),
        .EXPECT_CUSTOM (16'hFF00)
    ) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [7:0] key,
                        input logic [7:0] fc, input logic held);
        exp_t e;
        e.kind = kind; e.key = key; e.fc = fc; e.held = held;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [15:0] cust, input logic [7:0] key, input logic [7:0] inv);
        bus.clu_I = cust[3:0];   bus.cll_I = cust[7:4];
        bus.cru_I = cust[11:8];  bus.crl_I = cust[15:12];
        bus.ku_I  = key[3:0];    bus.kl_I  = key[7:4];
        bus.iku_I = inv[3:0];    bus.ikl_I = inv[7:4];
    endtask

    // One receiver episode: leader, count ramp to n, then flag and count drop together
    task automatic send_frame(input logic [5:0] n, input logic [15:0] cust,
                              input logic [7:0] key, input logic [7:0] inv, input int gap);
        set_fields(cust, key, inv);
        bus.lead_flag_I = 1'b1;
        bus.vaild_cnt_I = 6'd0;
        tick();
        for (int i = 1; i <= int'(n); i++) begin
            bus.vaild_cnt_I = 6'(i);
            tick();
        end
        tick();
        bus.lead_flag_I = 1'b0;
        bus.vaild_cnt_I = 6'd0;
        repeat (gap) tick();
    endtask

    // Monitor: every output pulse must match the next scoreboard entry;
    // also times the held level against the most recent reload
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_held = 1'b0;
        end else begin
            if (bus.key_valid_O || bus.key_repeat_O || bus.err_O) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event", {29'd0, bus.key_valid_O, bus.key_repeat_O, bus.err_O}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("event_kind", {29'd0, bus.key_valid_O, bus.key_repeat_O, bus.err_O}, {29'd0, e.kind});
                    chk("event_key",  {24'd0, bus.key_code_O},  {24'd0, e.key});
                    chk("event_fcnt", {24'd0, bus.frame_cnt_O}, {24'd0, e.fc});
                    chk("event_held", {31'd0, bus.key_held_O},  {31'd0, e.held});
                end
            end
            if (bus.key_valid_O || bus.key_repeat_O)
                last_reload = cyc;
            if (prev_held && !bus.key_held_O)
                chk("hold_length", 32'(cyc - last_reload), 32'(HOLD));
            prev_held = bus.key_held_O;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key"},    {24'd0, bus.key_code_O},  32'd0);
        chk({tag, "_custom"}, {16'd0, bus.custom_O},    32'd0);
        chk({tag, "_held"},   {31'd0, bus.key_held_O},  32'd0);
        chk({tag, "_fcnt"},   {24'd0, bus.frame_cnt_O}, 32'd0);
        chk({tag, "_pulses"}, {29'd0, bus.key_valid_O, bus.key_repeat_O, bus.err_O}, 32'd0);
        chk({tag, "_hex0"},   {25'd0, bus.HEX0_O}, 32'h40);
        chk({tag, "_hex1"},   {25'd0, bus.HEX1_O}, 32'h40);
        chk({tag, "_hex2"},   {25'd0, bus.HEX2_O}, 32'h40);
        chk({tag, "_hex3"},   {25'd0, bus.HEX3_O}, 32'h40);
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        checks = 0; errors = 0; cyc = 0; last_reload = 0; prev_held = 1'b0; m_fc = 8'd0;
        rst_n = 1'b0;
        bus.lead_flag_I = 1'b0;
        bus.vaild_cnt_I = 6'd0;
        set_fields(16'h0000, 8'h00, 8'h00);
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        // Repeat code with nothing held: ignored
        send_frame(6'd0, 16'hFF00, 8'h45, 8'hBA, 10);
        chk("repeat_no_hold_held", {31'd0, bus.key_held_O}, 32'd0);

        // Valid frame
        push(3'b100, 8'h45, 8'd1, 1'b1);
        send_frame(6'd32, 16'hFF00, 8'h45, 8'hBA, 10);
        chk("valid_custom", {16'd0, bus.custom_O}, 32'hFF00);
        chk("valid_hex0",   {25'd0, bus.HEX0_O}, 32'h12);
        chk("valid_hex1",   {25'd0, bus.HEX1_O}, 32'h19);
        chk("valid_hex2",   {25'd0, bus.HEX2_O}, 32'h40);

        // Three repeats, each inside the hold window
        for (int i = 0; i < 3; i++) begin
            push(3'b010, 8'h45, 8'd1, 1'b1);
            send_frame(6'd0, 16'hFF00, 8'h45, 8'hBA, 110);
        end
        repeat (260) tick();
        chk("held_after_expiry", {31'd0, bus.key_held_O}, 32'd0);

        // Bad inverse
        push(3'b001, 8'h45, 8'd1, 1'b0);
        send_frame(6'd32, 16'hFF00, 8'h45, 8'hBB, 10);
        chk("bad_inv_key", {24'd0, bus.key_code_O}, 32'h45);

        // Repeat after expiry: ignored
        send_frame(6'd0, 16'hFF00, 8'h45, 8'hBA, 10);
        chk("late_repeat_held", {31'd0, bus.key_held_O}, 32'd0);

        // Truncated frame
        push(3'b001, 8'h45, 8'd1, 1'b0);
        send_frame(6'd17, 16'hFF00, 8'h45, 8'hBA, 10);

        // Custom mismatch
        push(3'b001, 8'h45, 8'd1, 1'b0);
        send_frame(6'd32, 16'h00FF, 8'h12, 8'hED, 10);
        chk("mismatch_fcnt",   {24'd0, bus.frame_cnt_O}, 32'd1);
        chk("mismatch_custom", {16'd0, bus.custom_O},    32'hFF00);

        // Back-to-back frames: second leader rises while first is in CHECK
        push(3'b100, 8'h21, 8'd2, 1'b1);
        send_frame(6'd32, 16'hFF00, 8'h21, 8'hDE, 2);
        push(3'b100, 8'hF8, 8'd3, 1'b1);
        send_frame(6'd32, 16'hFF00, 8'hF8, 8'h07, 10);
        chk("f8_hex0", {25'd0, bus.HEX0_O}, 32'h00);
        chk("f8_hex1", {25'd0, bus.HEX1_O}, 32'h0E);
        m_fc = 8'd3;

        // Counter wrap: 253 more frames take the total to 256
        for (int i = 0; i < 253; i++) begin
            logic [7:0] k;
            k = 8'(i);
            m_fc = m_fc + 8'd1;
            push(3'b100, k, m_fc, 1'b1);
            send_frame(6'd32, 16'hFF00, k, ~k, 3);
        end
        repeat (5) tick();
        chk("wrap_fcnt", {24'd0, bus.frame_cnt_O}, 32'd0);
        repeat (260) tick();

        // Reset in the middle of a frame
        push(3'b100, 8'h5A, 8'd1, 1'b1);
        send_frame(6'd32, 16'hFF00, 8'h5A, 8'hA5, 10);
        set_fields(16'hFF00, 8'h33, 8'hCC);
        bus.lead_flag_I = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.vaild_cnt_I = 6'(i);
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 6; i <= 32; i++) begin
            bus.vaild_cnt_I = 6'(i);
            tick();
        end
        bus.lead_flag_I = 1'b0;
        bus.vaild_cnt_I = 6'd0;
        repeat (10) tick();
        chk("discarded_key",  {24'd0, bus.key_code_O},  32'd0);
        chk("discarded_fcnt", {24'd0, bus.frame_cnt_O}, 32'd0);

        // Fresh frame after reset
        push(3'b100, 8'h81, 8'd1, 1'b1);
        send_frame(6'd32, 16'hFF00, 8'h81, 8'h7E, 10);
        chk("final_hex0", {25'd0, bus.HEX0_O}, 32'h79);
        chk("final_hex1", {25'd0, bus.HEX1_O}, 32'h00);

        repeat (5) tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_key_decode.md
# ir_key_decode

Frame-level consumer for the NEC IR receiver. It watches the receiver's `lead_flag` and bit count to detect the end of each frame. It then validates the latched custom/key nibbles and emits a one-cycle key event, a held-key level with repeat-code handling, error and frame statistics, and four active-low seven-segment digits for the DE-series board.

## Interface
Parameters:
- `HOLD_CYCLES`, default 6_000_000: `key_held` timeout in CLOCK_50 cycles (120 ms), restarted by each valid frame or repeat.
- `CHECK_CUSTOM`, default 0: when 1, a frame is valid only if its custom code equals `EXPECT_CUSTOM`.
- `EXPECT_CUSTOM`, default 16'h00FF: expected `{custom_r, custom_l}`.

Ports:
- `CLOCK_50` in 1: 50 MHz clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `lead_flag_I` in 1: high from leader detection until frame end or timeout.
- `vaild_cnt_I` in 6: received bit count, 0..32.
- `clu_I`, `cll_I`, `cru_I`, `crl_I` in 4 each: custom_l[3:0], custom_l[7:4], custom_r[3:0], custom_r[7:4].
- `ku_I`, `kl_I`, `iku_I`, `ikl_I` in 4 each: key[3:0], key[7:4], inv_key[3:0], inv_key[7:4].
- `key_code_O` out 8: last valid key.
- `custom_O` out 16: last valid `{custom_r, custom_l}`.
- `key_valid_O` out 1: one-cycle pulse per valid new frame.
- `key_repeat_O` out 1: one-cycle pulse per accepted repeat code.
- `key_held_O` out 1: level; key considered pressed.
- `err_O` out 1: one-cycle pulse per rejected frame.
- `frame_cnt_O` out 8: valid-frame count, wraps 255→0.
- `HEX0_O`..`HEX3_O` out 7 each: active-low segments {g..a}. HEX0 = key[3:0], HEX1 = key[7:4], HEX2 = custom_l[3:0], HEX3 = custom_l[7:4].

## Operation
- FSM states: IDLE, RECV, CHECK.
  - IDLE→RECV when `lead_flag_I`=1.
  - RECV→CHECK when `lead_flag_I`=0.
  - CHECK→IDLE unconditionally, after exactly one cycle.
- In RECV, `max_cnt` (6 bit) ← max(`max_cnt`, `vaild_cnt_I`). It is cleared on entry to RECV. The upstream stage clears its count in the same cycle `lead_flag` drops, so `max_cnt` is the only frame-length record.
- Nibbles are sampled into shadow registers on the RECV→CHECK transition, when the upstream data is stable.
- CHECK evaluation:
  - `max_cnt`==32: valid if {kl,ku} == ~{ikl,iku} and, when `CHECK_CUSTOM`=1, custom matches. If valid: update `key_code_O`/`custom_O`, pulse `key_valid_O`, increment `frame_cnt_O`, set `key_held_O`, reload the hold counter. Otherwise pulse `err_O`; `key_code_O` is unchanged.
  - `max_cnt`==0: repeat code. If `key_held_O`=1, pulse `key_repeat_O` and reload the hold counter. Otherwise ignore, with no pulse.
  - `max_cnt` 1..31: truncated frame. Pulse `err_O`.
- Hold counter: 23 bit; it counts down while `key_held_O`=1. When it reaches 0, `key_held_O`←0. A reload in the same cycle as expiry wins, and `key_held_O` stays 1.
- A new leader during CHECK is not lost: CHECK→IDLE, then IDLE→RECV on the next cycle.
- HEX decode covers 0–F with the standard active-low patterns, e.g. 0→7'h40, 8→7'h00, F→7'h0E.

## Timing
- Reset values: `key_code_O`=0, `custom_O`=0, all pulses 0, `key_held_O`=0, `frame_cnt_O`=0, FSM=IDLE, hold counter=0, `HEX0_O`..`HEX3_O`=7'h40 (digit 0).
- Event latency: `lead_flag_I` observed low at clock edge N → CHECK during cycle N+1 → pulses and register updates visible after edge N+2, each pulse exactly 1 cycle.
- HEX outputs are registered and follow `key_code_O`/`custom_O` with 1 more cycle of latency.
- Reset mid-frame discards the frame. No output pulses until a complete RECV→CHECK sequence follows a rising `lead_flag_I` after reset.
- Frame spacing: frames are ≥ 40 ms apart, so there is no back-pressure. Consecutive frames must each produce their own event.

## Test plan
- Valid frame with custom 16'hFF00, key 8'h45, inv 8'hBA, count 32 → `key_valid_O` single pulse, `key_code_O`=8'h45, `frame_cnt_O`=1, `key_held_O`=1, HEX1/HEX0 = "4"/"5" (7'h19/7'h12).
- Key 8'h45 with inv 8'hBB → `err_O` pulse, no `key_valid_O`, `key_code_O` unchanged.
- Valid frame, then repeat episodes (count 0) every 108 ms ×3 → three `key_repeat_O` pulses. `key_held_O` stays 1 and drops exactly `HOLD_CYCLES` after the last reload.
- Repeat episode after reset with no prior frame → no pulses, `key_held_O`=0.
- Frame timing out at count 17 → `err_O` pulse. Then `CHECK_CUSTOM`=1 with custom mismatch → `err_O`, `frame_cnt_O` unchanged.
- 256 valid frames → `frame_cnt_O` wraps to 0. Assert `rst_n` mid-RECV → all outputs return to reset values immediately.
